// File: rtl/cvxif_issue_ctrl.sv
// Core-side CV-X-IF issue controller: drives one issue transaction at a time,
// follows it with commit/kill, tracks writeback IDs and registers results for writeback.
module cvxif_issue_ctrl #(
    parameter int unsigned NrRs           = 2,
    parameter int unsigned XLEN           = 32,
    parameter int unsigned IdWidth        = 3,
    parameter int unsigned MaxOutstanding = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   instr_valid_i,
    output logic                   instr_ready_o,
    input  logic [31:0]            instr_i,
    input  logic [NrRs*XLEN-1:0]   rs_i,
    input  logic [NrRs-1:0]        rs_valid_i,
    input  logic                   flush_i,
    output logic                   illegal_o,
    output logic                   x_issue_valid_o,
    output logic [31:0]            x_issue_instr_o,
    output logic [IdWidth-1:0]     x_issue_id_o,
    output logic [NrRs*XLEN-1:0]   x_issue_rs_o,
    output logic [NrRs-1:0]        x_issue_rs_valid_o,
    input  logic                   x_issue_ready_i,
    input  logic                   x_issue_accept_i,
    input  logic                   x_issue_writeback_i,
    output logic                   x_commit_valid_o,
    output logic [IdWidth-1:0]     x_commit_id_o,
    output logic                   x_commit_kill_o,
    input  logic                   x_result_valid_i,
    output logic                   x_result_ready_o,
    input  logic [IdWidth-1:0]     x_result_id_i,
    input  logic [XLEN-1:0]        x_result_data_i,
    input  logic [4:0]             x_result_rd_i,
    input  logic                   x_result_we_i,
    output logic                   wb_valid_o,
    input  logic                   wb_ready_i,
    output logic [IdWidth-1:0]     wb_id_o,
    output logic [4:0]             wb_rd_o,
    output logic [XLEN-1:0]        wb_data_o,
    output logic                   wb_we_o
);

    localparam int unsigned NrIds = 1 << IdWidth;
    localparam int unsigned OutW  = $clog2(MaxOutstanding + 1);
    localparam logic [OutW-1:0] MaxOut = OutW'(MaxOutstanding);

    if (MaxOutstanding > NrIds) begin : g_bad_cfg
        $error("MaxOutstanding must not exceed 2**IdWidth");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, COMMIT} state_e;

    state_e                 state_q, state_d;
    logic [31:0]            instr_q;
    logic [NrRs*XLEN-1:0]   rs_q;
    logic [NrRs-1:0]        rs_valid_q;
    logic [IdWidth-1:0]     issue_id_q;
    logic [IdWidth-1:0]     id_cnt_q;
    logic                   kill_pending_q, kill_pending_d;
    logic                   wb_set_q, wb_set_d;
    logic                   illegal_q, illegal_d;
    logic [OutW-1:0]        outstanding_q, outstanding_d;
    logic [NrIds-1:0]       pending_q, pending_d;
    logic                   wb_valid_q;
    logic [IdWidth-1:0]     wb_id_q;
    logic [4:0]             wb_rd_q;
    logic [XLEN-1:0]        wb_data_q;
    logic                   wb_we_q;

    logic instr_accept;
    logic issue_hs;
    logic kill_now;
    logic wb_inc;
    logic kill_dec;
    logic result_hs;
    logic res_dec;

    assign instr_ready_o    = !rst_i && (state_q == IDLE) && (outstanding_q < MaxOut) && !flush_i;
    assign instr_accept     = instr_valid_i && instr_ready_o;
    assign issue_hs         = (state_q == ISSUE) && x_issue_ready_i;
    assign kill_now         = kill_pending_q || flush_i;
    assign wb_inc           = issue_hs && x_issue_accept_i && x_issue_writeback_i && !kill_now;
    assign x_result_ready_o = !rst_i && (!wb_valid_q || wb_ready_i);
    assign result_hs        = x_result_valid_i && x_result_ready_o;
    assign res_dec          = result_hs && pending_q[x_result_id_i];
    // A late kill only releases its slot if no result for the same ID already did so.
    assign kill_dec         = (state_q == COMMIT) && kill_now && wb_set_q && pending_q[issue_id_q]
                              && !(res_dec && (x_result_id_i == issue_id_q));

    assign x_issue_valid_o    = (state_q == ISSUE);
    assign x_issue_instr_o    = instr_q;
    assign x_issue_id_o       = issue_id_q;
    assign x_issue_rs_o       = rs_q;
    assign x_issue_rs_valid_o = rs_valid_q;
    assign x_commit_valid_o   = (state_q == COMMIT);
    assign x_commit_id_o      = (state_q == COMMIT) ? issue_id_q : '0;
    assign x_commit_kill_o    = (state_q == COMMIT) && kill_now;
    assign illegal_o          = illegal_q;
    assign wb_valid_o         = wb_valid_q;
    assign wb_id_o            = wb_id_q;
    assign wb_rd_o            = wb_rd_q;
    assign wb_data_o          = wb_data_q;
    assign wb_we_o            = wb_we_q;

    always_comb begin
        state_d        = state_q;
        kill_pending_d = kill_pending_q;
        wb_set_d       = wb_set_q;
        illegal_d      = 1'b0;
        case (state_q)
            IDLE: begin
                kill_pending_d = 1'b0;
                wb_set_d       = 1'b0;
                if (instr_accept) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (flush_i) begin
                    kill_pending_d = 1'b1;
                end
                if (x_issue_ready_i) begin
                    if (x_issue_accept_i) begin
                        state_d  = COMMIT;
                        wb_set_d = wb_inc;
                    end else begin
                        state_d        = IDLE;
                        illegal_d      = 1'b1;
                        kill_pending_d = 1'b0;
                    end
                end
            end
            COMMIT: begin
                state_d        = IDLE;
                kill_pending_d = 1'b0;
                wb_set_d       = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    assign outstanding_d = outstanding_q + OutW'(wb_inc) - OutW'(res_dec) - OutW'(kill_dec);

    // Set wins over clear; a legal flow never sets and clears the same ID together.
    for (genvar gi = 0; gi < NrIds; gi++) begin : g_pending
        assign pending_d[gi] = (wb_inc && (issue_id_q == IdWidth'(gi))) ? 1'b1 :
                               ((result_hs && (x_result_id_i == IdWidth'(gi))) ||
                                (kill_dec && (issue_id_q == IdWidth'(gi)))) ? 1'b0 :
                               pending_q[gi];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q        <= IDLE;
            instr_q        <= '0;
            rs_q           <= '0;
            rs_valid_q     <= '0;
            issue_id_q     <= '0;
            id_cnt_q       <= '0;
            kill_pending_q <= 1'b0;
            wb_set_q       <= 1'b0;
            illegal_q      <= 1'b0;
            outstanding_q  <= '0;
            pending_q      <= '0;
        end else begin
            state_q        <= state_d;
            kill_pending_q <= kill_pending_d;
            wb_set_q       <= wb_set_d;
            illegal_q      <= illegal_d;
            outstanding_q  <= outstanding_d;
            pending_q      <= pending_d;
            if (instr_accept) begin
                instr_q    <= instr_i;
                rs_q       <= rs_i;
                rs_valid_q <= rs_valid_i;
                issue_id_q <= id_cnt_q;
            end
            if (issue_hs) begin
                id_cnt_q <= id_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wb_valid_q <= 1'b0;
            wb_id_q    <= '0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            wb_we_q    <= 1'b0;
        end else if (result_hs) begin
            wb_valid_q <= 1'b1;
            wb_id_q    <= x_result_id_i;
            wb_rd_q    <= x_result_rd_i;
            wb_data_q  <= x_result_data_i;
            wb_we_q    <= x_result_we_i;
        end else if (wb_ready_i) begin
            wb_valid_q <= 1'b0;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (!rst_i && result_hs) begin
            assert (pending_q[x_result_id_i])
                else $error("result for ID %0d with no pending writeback", x_result_id_i);
        end
    end
`endif

endmodule
